// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the fetch/data memory port arbiter
//
// Purpose : state and owner enumerations plus sizing constants used by
//           mem_port_arbiter and its wait counter.
// Contents: arb_state_t  IDLE / ISSUE / WAIT / RESP
//           owner_t      OWN_I (fetch, 0) / OWN_D (data, 1)
//           MEM_LAT_MAX  largest supported memory latency
//           CNT_W        width of the latency wait counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int unsigned MEM_LAT_MAX = 15;
  localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// rtl/mem_arb_wait_cnt.sv - loadable 4-bit down-counter with zero flag
//
// Purpose : counts the memory latency while the arbiter sits in WAIT.
//           The count stops at zero instead of wrapping so a stray
//           decrement can never turn a short wait into a long one.
// Ports   : clk        clock, rising edge
//           reset      synchronous, active-high; clears the count
//           load_i     load load_val_i (has priority over dec_i)
//           load_val_i value to load
//           dec_i      decrement by one when non-zero
//           zero_o     count is zero
module mem_arb_wait_cnt
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates a fetch port and a data port onto one fixed-latency memory port
//
// Purpose : one transaction at a time runs IDLE -> ISSUE -> WAIT -> RESP.
//           The winner's address, store flag and store data are captured at
//           the grant edge, so requester inputs may change freely afterwards.
//           Every output is driven straight from a register.
// Config  : macro ARB_ROUND_ROBIN_EN
//             undefined - simultaneous requests: data always wins
//             defined   - simultaneous requests: the port not served last wins
//           A lone requester always wins in both builds.
// Params  : MEM_LAT    memory read latency in cycles (1..15)
// Ports   : clk        clock, rising edge
//           reset      synchronous, active-high
//           i_req      fetch request, held until i_ack
//           i_addr     fetch address
//           i_ack      one-cycle pulse, i_rdata valid
//           i_rdata    fetched word
//           d_req      data request, held until d_ack
//           d_we       1 = store, 0 = load
//           d_addr     data address
//           d_wdata    store data
//           d_ack      one-cycle pulse, data access complete
//           d_rdata    loaded word (left unchanged by stores)
//           mem_en     one-cycle memory strobe
//           mem_we     memory write enable, only together with mem_en
//           mem_addr   latched address of current owner
//           mem_wdata  latched store data
//           mem_rdata  memory read data, valid MEM_LAT cycles after mem_en
//           busy       high whenever not IDLE
//           owner      0 = fetch, 1 = data; owner of the last grant
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  // The counter is loaded with MEM_LAT-1 at the end of ISSUE; WAIT then
  // lasts MEM_LAT cycles and samples mem_rdata in its last one.
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_t  state_q, state_d;
  owner_t      owner_q, owner_d;
  owner_t      grant;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        busy_q, busy_d;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;

  mem_arb_wait_cnt u_wait_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (LAT_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // owner_q doubles as the last-served record: it always holds the port of
  // the most recent grant and resets to fetch.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (i_req && d_req) begin
      grant = (owner_q == OWN_I) ? OWN_D : OWN_I;
    end else begin
      grant = d_req ? OWN_D : OWN_I;
    end
`else
    grant = d_req ? OWN_D : OWN_I;
`endif
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    mem_en_d  = 1'b0;
    mem_we_d  = 1'b0;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d  = ISSUE;
          owner_d  = grant;
          addr_d   = (grant == OWN_D) ? d_addr : i_addr;
          we_d     = d_we;
          wdata_d  = d_wdata;
          // Strobe is set on the way into ISSUE so it is visible in ISSUE.
          mem_en_d = 1'b1;
          mem_we_d = (grant == OWN_D) && d_we;
        end
      end
      ISSUE: begin
        cnt_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (cnt_zero) begin
          state_d = RESP;
          if (owner_q == OWN_I) begin
            i_rdata_d = mem_rdata;
            i_ack_d   = 1'b1;
          end else begin
            if (!we_q) begin
              d_rdata_d = mem_rdata;
            end
            d_ack_d = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter at MEM_LAT 1 and 4
module tb_mem_port_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset;
  logic        i_req [2];
  logic [31:0] i_addr [2];
  logic        i_ack [2];
  logic [31:0] i_rdata [2];
  logic        d_req [2];
  logic        d_we [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic        d_ack [2];
  logic [31:0] d_rdata [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy [2];
  logic        owner [2];

  mem_port_arbiter #(.MEM_LAT(LAT0)) u_dut0 (
    .clk(clk), .reset(reset),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_ack(i_ack[0]), .i_rdata(i_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .owner(owner[0])
  );

  mem_port_arbiter #(.MEM_LAT(LAT1)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_ack(i_ack[1]), .i_rdata(i_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .owner(owner[1])
  );

  // Memory device: read data appears exactly MEM_LAT cycles after the strobe
  // and is garbage in every other cycle.
  logic [31:0] dev_mem [logic [32:0]];
  logic [31:0] ref_mem [logic [32:0]];
  logic [31:0] pipe [2][16];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0000_0004) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] dev_rd(input int u, input logic [31:0] a);
    logic [32:0] k;
    k = {u[0], a};
    return dev_mem.exists(k) ? dev_mem[k] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input int u, input logic [31:0] a);
    logic [32:0] k;
    k = {u[0], a};
    return ref_mem.exists(k) ? ref_mem[k] : init_word(a);
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (mem_en[u] && mem_we[u]) dev_mem[{u[0], mem_addr[u]}] = mem_wdata[u];
      pipe[u][0] <= (mem_en[u] && !mem_we[u]) ? dev_rd(u, mem_addr[u]) : (32'hBAD0_0000 ^ 32'(cyc));
      for (int s = 1; s < 16; s++) pipe[u][s] <= pipe[u][s-1];
    end
  end
  assign mem_rdata[0] = pipe[0][LAT0-1];
  assign mem_rdata[1] = pipe[1][LAT1-1];

  typedef struct { int cyc; logic [31:0] addr; logic we; logic [31:0] wdata; } en_ev_t;
  typedef struct { int cyc; logic d; logic [31:0] rdata; logic [31:0] maddr; logic own; } ack_ev_t;

  en_ev_t      en_q [$];
  ack_ev_t     ack_q [$];
  int          busy_cnt;
  int          we_viol;
  int          vectors = 0;
  int          miscompares = 0;
  bit          last_d [2];
  logic [31:0] ref_ird [2];
  logic [31:0] ref_drd [2];

  task automatic tick(input int u);
    @(negedge clk);
    if (mem_en[u]) en_q.push_back('{cyc: cyc, addr: mem_addr[u], we: mem_we[u], wdata: mem_wdata[u]});
    if (i_ack[u]) ack_q.push_back('{cyc: cyc, d: 1'b0, rdata: i_rdata[u], maddr: mem_addr[u], own: owner[u]});
    if (d_ack[u]) ack_q.push_back('{cyc: cyc, d: 1'b1, rdata: d_rdata[u], maddr: mem_addr[u], own: owner[u]});
    if (busy[u]) busy_cnt++;
    if (mem_we[u] && !mem_en[u]) we_viol++;
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      last_d[u] = 1'b0; ref_ird[u] = '0; ref_drd[u] = '0;
    end
  endtask

  // One arbitration session: raise the requested ports while the DUT is
  // idle, drop each request after its final ack, then compare every strobe
  // and ack against the rule-based expectation.
  task automatic session(input int u, input bit do_i, input int n_d, input bit we,
                         input bit chg, input bit early,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd);
    int lat, n, dleft, dk, gi, budget, dcnt;
    bit ip, gd;
    logic [31:0] ea, ew, er;
    en_ev_t e;
    ack_ev_t a;
    lat = (u == 0) ? LAT0 : LAT1;
    budget = 50;
    while (busy[u] !== 1'b0 && budget > 0) begin tick(u); budget--; end
    en_q.delete(); ack_q.delete(); busy_cnt = 0; we_viol = 0; dcnt = 0;
    n = cyc;
    i_req[u] = do_i; i_addr[u] = ia;
    d_req[u] = (n_d > 0); d_we[u] = we; d_addr[u] = da; d_wdata[u] = wd;
    budget = 200;
    while ((i_req[u] || d_req[u]) && budget > 0) begin
      tick(u); budget--;
      if (cyc == n + 1 && chg) begin d_addr[u] = da + 32'h200; d_wdata[u] = ~wd; end
      if (cyc == n + 1 && early) begin i_req[u] = 1'b0; d_req[u] = 1'b0; end
      if (i_ack[u]) i_req[u] = 1'b0;
      if (d_ack[u]) begin dcnt++; if (dcnt >= n_d) d_req[u] = 1'b0; end
    end
    if (budget == 0) begin
      vectors++; miscompares++;
      $display("FAIL timeout dut%0d: requests still pending after 200 cycles, need all acked", u);
      i_req[u] = 1'b0; d_req[u] = 1'b0;
    end
    for (int t = 0; t < lat + 4; t++) tick(u);

    ip = do_i; dleft = n_d; dk = 0; gi = 0;
    while (ip || dleft > 0) begin
`ifdef ARB_ROUND_ROBIN_EN
      gd = (ip && dleft > 0) ? !last_d[u] : (dleft > 0);
`else
      gd = (dleft > 0);
`endif
      if (gd) begin
        ea = (dk > 0 && chg) ? da + 32'h200 : da;
        ew = (dk > 0 && chg) ? ~wd : wd;
        if (we) begin
          ref_mem[{u[0], ea}] = ew; er = ref_drd[u];
        end else begin
          ref_drd[u] = ref_rd(u, ea); er = ref_drd[u];
        end
      end else begin
        ea = ia; ew = wd;
        ref_ird[u] = ref_rd(u, ea); er = ref_ird[u];
      end
      vectors++;
      if (gi >= en_q.size() || gi >= ack_q.size()) begin
        miscompares++;
        $display("FAIL missing_event dut%0d grant %0d: got %0d strobes %0d acks, need %0d", u, gi, en_q.size(), ack_q.size(), gi + 1);
      end else begin
        e = en_q[gi]; a = ack_q[gi];
        vectors++;
        if (e.cyc != n + 1) begin miscompares++; $display("FAIL mem_en_cycle dut%0d grant %0d: got %0d need %0d", u, gi, e.cyc, n + 1); end
        vectors++;
        if (e.addr !== ea) begin miscompares++; $display("FAIL mem_addr dut%0d grant %0d: got %h need %h", u, gi, e.addr, ea); end
        vectors++;
        if (e.we !== (gd && we)) begin miscompares++; $display("FAIL mem_we dut%0d grant %0d: got %b need %b", u, gi, e.we, gd && we); end
        if (gd && we) begin
          vectors++;
          if (e.wdata !== ew) begin miscompares++; $display("FAIL mem_wdata dut%0d grant %0d: got %h need %h", u, gi, e.wdata, ew); end
        end
        vectors++;
        if (a.cyc != n + lat + 2) begin miscompares++; $display("FAIL ack_cycle dut%0d grant %0d: got %0d need %0d", u, gi, a.cyc, n + lat + 2); end
        vectors++;
        if (a.d !== gd || a.own !== gd) begin miscompares++; $display("FAIL ack_port dut%0d grant %0d: got ack_d=%b owner=%b need %b", u, gi, a.d, a.own, gd); end
        vectors++;
        if (a.rdata !== er) begin miscompares++; $display("FAIL rdata dut%0d grant %0d: got %h need %h", u, gi, a.rdata, er); end
        vectors++;
        if (a.maddr !== ea) begin miscompares++; $display("FAIL held_addr dut%0d grant %0d: got %h need %h", u, gi, a.maddr, ea); end
      end
      last_d[u] = gd;
      if (gd) begin dleft--; dk++; end else ip = 1'b0;
      n = n + lat + 3;
      gi++;
    end
    vectors++;
    if (en_q.size() != gi || ack_q.size() != gi) begin
      miscompares++;
      $display("FAIL event_count dut%0d: got %0d strobes %0d acks, need %0d each", u, en_q.size(), ack_q.size(), gi);
    end
    vectors++;
    if (busy_cnt != gi * (lat + 2)) begin miscompares++; $display("FAIL busy_cycles dut%0d: got %0d need %0d", u, busy_cnt, gi * (lat + 2)); end
    vectors++;
    if (we_viol != 0) begin miscompares++; $display("FAIL mem_we_without_en dut%0d: got %0d cycles need 0", u, we_viol); end
    vectors++;
    if (i_rdata[u] !== ref_ird[u] || d_rdata[u] !== ref_drd[u]) begin
      miscompares++;
      $display("FAIL rdata_regs dut%0d: got i=%h d=%h need i=%h d=%h", u, i_rdata[u], d_rdata[u], ref_ird[u], ref_drd[u]);
    end
  endtask

  task automatic check_reset_outputs(input int u, input string tag);
    vectors++;
    if ({i_ack[u], d_ack[u], mem_en[u], mem_we[u], busy[u], owner[u]} !== 6'b0) begin
      miscompares++;
      $display("FAIL %s_ctrl dut%0d: got i_ack/d_ack/en/we/busy/owner=%b need 000000", tag, u,
               {i_ack[u], d_ack[u], mem_en[u], mem_we[u], busy[u], owner[u]});
    end
    vectors++;
    if ({mem_addr[u], mem_wdata[u], i_rdata[u], d_rdata[u]} !== 128'b0) begin
      miscompares++;
      $display("FAIL %s_data dut%0d: got addr=%h wdata=%h i_rdata=%h d_rdata=%h need all 0", tag, u,
               mem_addr[u], mem_wdata[u], i_rdata[u], d_rdata[u]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      i_req[u] = 1'b0; i_addr[u] = '0; d_req[u] = 1'b0; d_we[u] = 1'b0; d_addr[u] = '0; d_wdata[u] = '0;
    end
    tick(0); tick(0); tick(0);
    for (int u = 0; u < 2; u++) check_reset_outputs(u, "reset");
    reset = 1'b0;
    model_reset();
    tick(0);
  endtask

  task automatic test_fetch();
    session(0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h0, 32'h0);
    vectors++;
    if (i_rdata[0] !== 32'h0010_0093) begin miscompares++; $display("FAIL fetch_word: got %h need 00100093", i_rdata[0]); end
  endtask

  task automatic test_store();
    session(0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF);
  endtask

  task automatic test_load_latency();
    session(1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0200, 32'h0);
  endtask

  task automatic test_arbitration();
    for (int u = 0; u < 2; u++) begin
      session(u, 1'b1, 1, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'h0000_0100, 32'h0);
      session(u, 1'b0, 1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0040, 32'h1234_5678);
      session(u, 1'b1, 1, 1'b0, 1'b0, 1'b0, 32'h0000_000C, 32'h0000_0040, 32'h0);
    end
  endtask

  task automatic test_early_drop();
    session(0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'h0);
    session(1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0020, 32'hA5A5_0F0F);
  endtask

  task automatic test_back_to_back();
    session(0, 1'b0, 2, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 32'h0);
    session(1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 32'hCAFE_F00D);
  endtask

  task automatic test_reset_mid();
    int n, budget;
    budget = 50;
    while (busy[1] !== 1'b0 && budget > 0) begin tick(1); budget--; end
    en_q.delete(); ack_q.delete();
    n = cyc;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h0000_0200;
    while (cyc < n + 3) tick(1);
    reset = 1'b1; d_req[1] = 1'b0;
    tick(1);
    for (int u = 0; u < 2; u++) check_reset_outputs(u, "reset_mid");
    reset = 1'b0;
    model_reset();
    for (int t = 0; t < 10; t++) tick(1);
    vectors++;
    if (ack_q.size() != 0) begin miscompares++; $display("FAIL aborted_ack: got %0d acks need 0", ack_q.size()); end
    session(1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0200, 32'h0);
  endtask

  task automatic test_random();
    int u, n_d;
    bit do_i, we, chg, early;
    for (int it = 0; it < 30; it++) begin
      u = int'($urandom_range(0, 1));
      do_i = 1'($urandom_range(0, 1));
      n_d = int'($urandom_range(0, 2));
      if (!do_i && n_d == 0) do_i = 1'b1;
      we = 1'($urandom_range(0, 1));
      chg = !do_i && (1'($urandom_range(0, 1)));
      early = (do_i != (n_d > 0)) && (n_d < 2) && (1'($urandom_range(0, 1)));
      session(u, do_i, n_d, we, chg, early,
              {26'd0, 4'($urandom_range(0, 15)), 2'b00},
              {26'd0, 4'($urandom_range(0, 15)), 2'b00},
              $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_load_latency();
    test_arbitration();
    test_early_drop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
